cluster_tx_scheduler: RTL and testbench

//  Sits after cluster_packer. Once per bunch crossing it queues that BX's eight 14-bit clusters
//  ({cnt[2:0], adr[10:0]}) into a FIFO, skipping invalid ones. It caps the clusters taken per BX,

---
 rtl/cluster_tx_scheduler_if.sv | 37 +++
 rtl/cluster_tx_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_cluster_tx_scheduler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_tx_scheduler_if.sv
// Per-BX cluster input bundle plus the valid/ready cluster stream of cluster_tx_scheduler.
// slave = scheduler side, master = packer/consumer side.
interface cluster_tx_scheduler_if #(
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             cluster_strobe;
  logic [13:0]      cluster0;
  logic [13:0]      cluster1;
  logic [13:0]      cluster2;
  logic [13:0]      cluster3;
  logic [13:0]      cluster4;
  logic [13:0]      cluster5;
  logic [13:0]      cluster6;
  logic [13:0]      cluster7;
  logic [3:0]       max_clusters;
  logic [13:0]      tx_cluster;
  logic             tx_valid;
  logic             tx_ready;
  logic [CW-1:0]    fifo_count;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;

  modport slave (
    input  cluster_strobe, cluster0, cluster1, cluster2, cluster3,
           cluster4, cluster5, cluster6, cluster7, max_clusters, tx_ready,
    output tx_cluster, tx_valid, fifo_count, drop_cnt, busy
  );

  modport master (
    output cluster_strobe, cluster0, cluster1, cluster2, cluster3,
           cluster4, cluster5, cluster6, cluster7, max_clusters, tx_ready,
    input  tx_cluster, tx_valid, fifo_count, drop_cnt, busy
  );
endinterface

// File: rtl/cluster_tx_scheduler.sv
// Queues each BX's eight packer clusters (two per cycle, capped per BX) into a FIFO and
// streams them out one per clock4x; refused or overrun clusters bump a saturating drop counter.
module cluster_tx_scheduler #(
  parameter int FIFO_DEPTH = 64,
  parameter int MAX_ADR    = 1535,
  parameter int CNT_W      = 16
) (
  input  logic                  clock4x,
  input  logic                  global_reset_n,
  cluster_tx_scheduler_if.slave bus
);
  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              CW         = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C    = CW'(FIFO_DEPTH);
  localparam logic [13:0]     EMPTY_SLOT = {3'b000, 11'h7FF};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN0 = 3'd1,
    S_SCAN1 = 3'd2,
    S_SCAN2 = 3'd3,
    S_SCAN3 = 3'd4
  } state_t;

  function automatic logic slot_valid(input logic [10:0] adr);
    return (32'(adr) <= MAX_ADR);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [13:0]      r_hold [8];
  logic [3:0]       r_cap;
  logic [3:0]       r_acc;
  logic [13:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [13:0]      r_tx_cluster;
  logic             r_tx_valid;
  logic [CNT_W-1:0] r_drop;
  logic             r_busy;

  logic             w_scanning;
  logic [1:0]       w_pair;
  logic [13:0]      w_slot_a;
  logic [13:0]      w_slot_b;
  logic [CW-1:0]    w_space;
  logic             w_elig_a;
  logic             w_elig_b;
  logic             w_take_a;
  logic             w_take_b;
  logic [3:0]       w_acc_a;
  logic [3:0]       w_acc_nxt;
  logic [3:0]       w_acc_ov;
  logic [3:0]       w_ov_cnt;
  logic             w_ov_hit;
  logic             w_overrun;
  logic [1:0]       w_nwr;
  logic [13:0]      w_wdata0;
  logic [13:0]      w_wdata1;
  logic [AW-1:0]    w_wptr1;
  logic [3:0]       w_drop_inc;
  logic [CNT_W:0]   w_drop_sum;
  logic             w_pop;
  logic             w_load;
  logic [CW-1:0]    w_mem_cnt;
  logic [CW-1:0]    w_count_nxt;

  // Next-state: a strobe always restarts the scan, otherwise walk SCAN0..SCAN3 back to IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (bus.cluster_strobe) begin
      w_state_nxt = S_SCAN0;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_SCAN0: w_state_nxt = S_SCAN1;
        S_SCAN1: w_state_nxt = S_SCAN2;
        S_SCAN2: w_state_nxt = S_SCAN3;
        S_SCAN3: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Decode which held pair the current state examines
  always_comb begin
    w_scanning = 1'b0;
    w_pair     = 2'd0;
    case (r_state)
      S_SCAN0: begin w_scanning = 1'b1; w_pair = 2'd0; end
      S_SCAN1: begin w_scanning = 1'b1; w_pair = 2'd1; end
      S_SCAN2: begin w_scanning = 1'b1; w_pair = 2'd2; end
      S_SCAN3: begin w_scanning = 1'b1; w_pair = 2'd3; end
      default: begin w_scanning = 1'b0; w_pair = 2'd0; end
    endcase
  end

  assign w_slot_a = r_hold[{w_pair, 1'b0}];
  assign w_slot_b = r_hold[{w_pair, 1'b1}];
  assign w_space  = DEPTH_C - r_count;

  // Pair admission: cap first, then space judged on the occupancy at the start of the cycle
  always_comb begin
    w_elig_a   = w_scanning & slot_valid(w_slot_a[10:0]) & (r_acc < r_cap);
    w_take_a   = w_elig_a & (w_space != {CW{1'b0}});
    w_acc_a    = r_acc + {3'b000, w_take_a};
    w_elig_b   = w_scanning & slot_valid(w_slot_b[10:0]) & (w_acc_a < r_cap);
    w_take_b   = w_elig_b & (w_space > CW'(w_take_a));
    w_acc_nxt  = w_acc_a + {3'b000, w_take_b};
    w_nwr      = {1'b0, w_take_a} + {1'b0, w_take_b};
    w_wdata0   = w_take_a ? w_slot_a : w_slot_b;
    w_wdata1   = w_slot_b;
    w_overrun  = bus.cluster_strobe & w_scanning & (r_state != S_SCAN3);
    w_acc_ov   = w_acc_nxt;
    w_ov_cnt   = 4'd0;
    w_ov_hit   = 1'b0;
    for (int s = 0; s < 8; s++) begin
      w_ov_hit = w_overrun & (2'(s >> 1) > w_pair) & slot_valid(r_hold[s][10:0]) & (w_acc_ov < r_cap);
      w_acc_ov = w_acc_ov + {3'b000, w_ov_hit};
      w_ov_cnt = w_ov_cnt + {3'b000, w_ov_hit};
    end
    w_drop_inc = {3'b000, w_elig_a & ~w_take_a} + {3'b000, w_elig_b & ~w_take_b} + w_ov_cnt;
    w_drop_sum = {1'b0, r_drop} + (CNT_W + 1)'(w_drop_inc);
  end

  // The head register is loaded from memory, so memory holds occupancy minus the head
  assign w_pop       = r_tx_valid & bus.tx_ready;
  assign w_mem_cnt   = r_count - CW'(r_tx_valid);
  assign w_load      = (w_mem_cnt != {CW{1'b0}}) & (~r_tx_valid | w_pop);
  assign w_count_nxt = r_count + CW'(w_nwr) - CW'(w_pop);
  assign w_wptr1     = r_wptr + AW'(1);

  // State register
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Hold registers, clamped cap and per-BX accepted count
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      for (int i = 0; i < 8; i++) r_hold[i] <= EMPTY_SLOT;
      r_cap <= 4'd0;
      r_acc <= 4'd0;
    end else if (bus.cluster_strobe) begin
      r_hold[0] <= bus.cluster0;
      r_hold[1] <= bus.cluster1;
      r_hold[2] <= bus.cluster2;
      r_hold[3] <= bus.cluster3;
      r_hold[4] <= bus.cluster4;
      r_hold[5] <= bus.cluster5;
      r_hold[6] <= bus.cluster6;
      r_hold[7] <= bus.cluster7;
      r_cap     <= (bus.max_clusters > 4'd8) ? 4'd8 : bus.max_clusters;
      r_acc     <= 4'd0;
    end else begin
      r_acc <= w_acc_nxt;
    end
  end

  // Queue storage, two compacted writes per cycle
  always_ff @(posedge clock4x) begin
    if (w_nwr != 2'd0) r_mem[r_wptr]  <= w_wdata0;
    if (w_nwr == 2'd2) r_mem[w_wptr1] <= w_wdata1;
  end

  // Pointers, occupancy and the registered head
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_wptr       <= {AW{1'b0}};
      r_rptr       <= {AW{1'b0}};
      r_count      <= {CW{1'b0}};
      r_tx_cluster <= 14'd0;
      r_tx_valid   <= 1'b0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_nwr);
      r_count <= w_count_nxt;
      if (w_load) begin
        r_tx_cluster <= r_mem[r_rptr];
        r_tx_valid   <= 1'b1;
        r_rptr       <= r_rptr + AW'(1);
      end else if (w_pop) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  // Saturating drop counter and busy flag
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      r_drop <= {CNT_W{1'b0}};
      r_busy <= 1'b0;
    end else begin
      r_drop <= w_drop_sum[CNT_W] ? {CNT_W{1'b1}} : w_drop_sum[CNT_W-1:0];
      r_busy <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.tx_cluster = r_tx_cluster;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.fifo_count = r_count;
  assign bus.drop_cnt   = r_drop;
  assign bus.busy       = r_busy;
endmodule

// File: tb/tb_cluster_tx_scheduler.sv
// Directed scenarios for cluster_tx_scheduler; expected clusters go into a scoreboard queue
// that a negedge monitor pops on every accepted handshake.
module tb_cluster_tx_scheduler;
  localparam logic [13:0] EMPTY = {3'b000, 11'h7FF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cluster_tx_scheduler_if #(.FIFO_DEPTH(64), .CNT_W(16)) bus ();

  cluster_tx_scheduler #(.FIFO_DEPTH(64), .MAX_ADR(1535), .CNT_W(16)) dut (
    .clock4x        (clk),
    .global_reset_n (rst_n),
    .bus            (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_drop = 0;
  logic [13:0] sb[$];
  logic [13:0] prev_head = 14'd0;
  logic        prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each accepted cluster with the scoreboard head; head must hold while stalled
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) check("head_stable", {17'd0, bus.tx_valid, bus.tx_cluster}, {17'd0, 1'b1, prev_head});
      if (bus.tx_valid && bus.tx_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h expected none", bus.tx_cluster);
        end else begin
          check("tx_cluster", {18'd0, bus.tx_cluster}, {18'd0, sb[0]});
          void'(sb.pop_front());
        end
      end
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_head  <= bus.tx_cluster;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0][13:0] mk(input int base, input logic [7:0] vm);
    logic [7:0][13:0] c;
    for (int s = 0; s < 8; s++) c[s] = vm[s] ? {3'(s), 11'(base + s)} : EMPTY;
    return c;
  endfunction

  task automatic expect_slots(input logic [7:0][13:0] c, input logic [7:0] m);
    for (int s = 0; s < 8; s++) if (m[s]) sb.push_back(c[s]);
  endtask

  task automatic bx(input logic [7:0][13:0] c, input logic [3:0] mc);
    bus.cluster0 = c[0]; bus.cluster1 = c[1]; bus.cluster2 = c[2]; bus.cluster3 = c[3];
    bus.cluster4 = c[4]; bus.cluster5 = c[5]; bus.cluster6 = c[6]; bus.cluster7 = c[7];
    bus.max_clusters   = mc;
    bus.cluster_strobe = 1'b1;
    tick();
    bus.cluster_strobe = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((sb.size() != 0 || bus.tx_valid || bus.busy || bus.fifo_count != 7'd0) && cyc < 3000) begin
      bus.tx_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    check({name, "_timeout"}, 32'(cyc < 3000), 32'd1);
    check({name, "_count0"}, 32'(bus.fifo_count), 32'd0);
    check({name, "_left"}, 32'(sb.size()), 32'd0);
  endtask

  logic [7:0][13:0] c;
  logic [7:0][13:0] c2;
  logic [7:0][13:0] c3;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cluster_strobe = 1'b0;
    bus.cluster0 = EMPTY; bus.cluster1 = EMPTY; bus.cluster2 = EMPTY; bus.cluster3 = EMPTY;
    bus.cluster4 = EMPTY; bus.cluster5 = EMPTY; bus.cluster6 = EMPTY; bus.cluster7 = EMPTY;
    bus.max_clusters = 4'd8;
    bus.tx_ready     = 1'b0;
    repeat (3) tick();
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_cluster", 32'(bus.tx_cluster), 32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: single cluster, latency N+2
    bus.tx_ready = 1'b1;
    c = mk(0, 8'h00);
    c[0] = 14'h0805;
    sb.push_back(14'h0805);
    bx(c, 4'd8);
    check("s1_busy", 32'(bus.busy), 32'd1);
    tick();
    check("s1_valid_n1", 32'(bus.tx_valid), 32'd0);
    tick();
    check("s1_valid_n2", 32'(bus.tx_valid), 32'd1);
    check("s1_data_n2", 32'(bus.tx_cluster), 32'h0805);
    tick();
    check("s1_valid_n3", 32'(bus.tx_valid), 32'd0);
    drain("s1");
    check("s1_drop", 32'(bus.drop_cnt), 32'd0);

    // 2: eight clusters held back, then streamed on consecutive cycles
    bus.tx_ready = 1'b0;
    c = mk(0, 8'hFF);
    expect_slots(c, 8'hFF);
    bx(c, 4'd8);
    repeat (4) tick();
    check("s2_count8", 32'(bus.fifo_count), 32'd8);
    check("s2_busy0", 32'(bus.busy), 32'd0);
    check("s2_head", 32'(bus.tx_cluster), 32'h0000);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("s2_consecutive", 32'(bus.tx_valid), 32'd1);
      tick();
    end
    check("s2_empty", 32'(bus.tx_valid), 32'd0);

    // 3: cap 3, cap 0, cap >8, address boundary
    c = mk(16, 8'hFF);
    expect_slots(c, 8'h07);
    bx(c, 4'd3);
    drain("s3_cap3");
    check("s3_drop", 32'(bus.drop_cnt), 32'd0);
    bus.tx_ready = 1'b1;
    bx(c, 4'd0);
    repeat (6) tick();
    check("s3_cap0_count", 32'(bus.fifo_count), 32'd0);
    check("s3_cap0_valid", 32'(bus.tx_valid), 32'd0);
    c = mk(32, 8'hFF);
    expect_slots(c, 8'hFF);
    bx(c, 4'd12);
    drain("s3_cap12");
    c = mk(0, 8'h00);
    c[0] = {3'd1, 11'd1536};
    c[1] = {3'd2, 11'd1535};
    sb.push_back({3'd2, 11'd1535});
    bx(c, 4'd8);
    drain("s3_maxadr");
    check("s3_drop_end", 32'(bus.drop_cnt), 32'd0);

    // 4: fill to 64, ninth BX all dropped, then one free slot
    bus.tx_ready = 1'b0;
    for (int b = 0; b < 9; b++) begin
      c = mk(64 + b * 8, 8'hFF);
      if (b < 8) expect_slots(c, 8'hFF);
      bx(c, 4'd8);
      repeat (3) tick();
    end
    tick();
    exp_drop += 8;
    check("s4_full", 32'(bus.fifo_count), 32'd64);
    check("s4_drop8", 32'(bus.drop_cnt), 32'(exp_drop));
    bus.tx_ready = 1'b1;
    tick();
    bus.tx_ready = 1'b0;
    check("s4_count63", 32'(bus.fifo_count), 32'd63);
    c = mk(200, 8'h1F);
    expect_slots(c, 8'h01);
    bx(c, 4'd8);
    repeat (4) tick();
    exp_drop += 4;
    check("s4_refull", 32'(bus.fifo_count), 32'd64);
    check("s4_drop12", 32'(bus.drop_cnt), 32'(exp_drop));
    drain("s4");

    // 5: strobes two apart overrun, four apart do not
    bus.tx_ready = 1'b0;
    c  = mk(300, 8'hFF);
    c2 = mk(310, 8'hFF);
    c3 = mk(320, 8'hFF);
    expect_slots(c, 8'h0F);
    expect_slots(c2, 8'h0F);
    expect_slots(c3, 8'hFF);
    bx(c, 4'd8);
    tick();
    bx(c2, 4'd8);
    tick();
    bx(c3, 4'd8);
    repeat (4) tick();
    exp_drop += 8;
    check("s5_overrun_drop", 32'(bus.drop_cnt), 32'(exp_drop));
    check("s5_overrun_count", 32'(bus.fifo_count), 32'd16);
    drain("s5a");
    c  = mk(400, 8'hFF);
    c2 = mk(410, 8'hFF);
    expect_slots(c, 8'hFF);
    expect_slots(c2, 8'hFF);
    bx(c, 4'd8);
    repeat (3) tick();
    bx(c2, 4'd8);
    repeat (4) tick();
    check("s5_backtoback_drop", 32'(bus.drop_cnt), 32'(exp_drop));
    drain("s5b");

    // 6: reset during SCAN1 with six queued
    bus.tx_ready = 1'b0;
    c = mk(500, 8'h3F);
    expect_slots(c, 8'h3F);
    bx(c, 4'd8);
    repeat (4) tick();
    check("s6_count6", 32'(bus.fifo_count), 32'd6);
    c2 = mk(510, 8'hFC);
    bx(c2, 4'd8);
    tick();
    check("s6_busy_scan1", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    sb.delete();
    exp_drop = 0;
    tick();
    check("s6_valid0", 32'(bus.tx_valid), 32'd0);
    check("s6_count0", 32'(bus.fifo_count), 32'd0);
    check("s6_drop0", 32'(bus.drop_cnt), 32'd0);
    check("s6_busy0", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();
    c = mk(600, 8'hFF);
    expect_slots(c, 8'hFF);
    bx(c, 4'd8);
    repeat (4) tick();
    check("s6_count8", 32'(bus.fifo_count), 32'd8);
    drain("s6");
    check("s6_drop_end", 32'(bus.drop_cnt), 32'(exp_drop));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
